result_bcd_conv: RTL and testbench

RESULT_BCD_CONV -- requirements
Module: result_bcd_conv

---
 rtl/result_bcd_conv_if.sv | 11 +
 rtl/result_bcd_conv.sv | 70 +++++++
 tb/tb_result_bcd_conv.sv | 139 +++++++++++++
 3 files changed

// File: rtl/result_bcd_conv_if.sv
// result_bcd_conv_if: start/value request and BCD result bundle for result_bcd_conv
interface result_bcd_conv_if;
    logic        start;
    logic [11:0] value;
    logic        busy;
    logic        done;
    logic        neg;
    logic [3:0]  dig3, dig2, dig1, dig0;
    modport master (output start, value, input busy, done, neg, dig3, dig2, dig1, dig0);
    modport slave  (input start, value, output busy, done, neg, dig3, dig2, dig1, dig0);
endinterface

// File: rtl/result_bcd_conv.sv
// result_bcd_conv: 12-bit signed to sign + 4-digit BCD via sequential double dabble.
// Optional leading-zero blanking with LEADING_ZERO_BLANK_EN.
module result_bcd_conv (
    input logic clk,
    input logic rst,
    result_bcd_conv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
    state_t state, state_nx;
    logic [11:0] mag;
    logic [15:0] bcd, adj, dig_nx;
    logic [3:0]  cnt;
    logic        sign, done, neg;
    logic [15:0] dig;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.start) state_nx = SHIFT;
        else if (state == SHIFT && cnt == 4'd11) state_nx = FINISH;
        else if (state == FINISH) state_nx = IDLE;
    end
`ifdef LEADING_ZERO_BLANK_EN
    logic blank3, blank2, blank1;
    always_comb begin
        blank3 = bcd[15:12] == 4'd0;
        blank2 = blank3 && bcd[11:8] == 4'd0;
        blank1 = blank2 && bcd[7:4] == 4'd0;
        dig_nx = {blank3 ? 4'hF : bcd[15:12], blank2 ? 4'hF : bcd[11:8],
                  blank1 ? 4'hF : bcd[7:4], bcd[3:0]};
    end
`else
    always_comb dig_nx = bcd;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mag   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            done  <= 1'b0;
            neg   <= 1'b0;
            dig   <= '0;
        end else begin
            state <= state_nx;
            done  <= state == FINISH;
            if (state == IDLE && bus.start) begin
                // 0x800 negates to itself, which is the correct unsigned 2048
                mag  <= bus.value[11] ? 12'(~bus.value + 12'd1) : bus.value;
                sign <= bus.value[11];
                bcd  <= '0;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                {bcd, mag} <= {adj[14:0], mag, 1'b0};
                cnt        <= cnt + 4'd1;
            end else if (state == FINISH) begin
                dig <= dig_nx;
                neg <= sign;
            end
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = done;
    assign bus.neg  = neg;
    assign {bus.dig3, bus.dig2, bus.dig1, bus.dig0} = dig;
endmodule

// File: tb/tb_result_bcd_conv.sv
// tb_result_bcd_conv: table-driven directed checks of result_bcd_conv plus overlap and reset-abort sequences.
module tb_result_bcd_conv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    result_bcd_conv_if bus ();
    result_bcd_conv dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] value;
        logic        neg;
        logic [15:0] bcd;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    logic        prev_neg = 1'b0;
    logic [15:0] prev_dig = 16'h0000;

    function automatic logic [15:0] shown(input logic [15:0] b);
        logic [15:0] r;
        r = b;
`ifdef LEADING_ZERO_BLANK_EN
        if (r[15:12] == 4'd0) begin
            r[15:12] = 4'hF;
            if (r[11:8] == 4'd0) begin
                r[11:8] = 4'hF;
                if (r[7:4] == 4'd0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] digs();
        return {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
    endfunction

    // Called at a negedge; asserts start, then watches busy/done and output hold until done.
    task automatic run_conv(input logic [11:0] v, input logic exp_neg, input logic [15:0] exp_bcd,
                            input int ovl_edge, input logic [11:0] ovl_val);
        int lat;
        bus.start = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_edge0", bus.busy, 1);
        chk("done_fall", bus.done, 0);
        lat = 0;
        while (!bus.done && lat < 20) begin
            if (lat + 1 == ovl_edge) begin
                bus.start = 1'b1;
                bus.value = ovl_val;
            end
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (!bus.done && lat < 13) begin
                if (!bus.busy) chk("busy_hold", bus.busy, 1);
                if (digs() !== prev_dig || bus.neg !== prev_neg)
                    chk("out_hold", {bus.neg, digs()}, {prev_neg, prev_dig});
            end
        end
        chk("latency", lat, 13);
        chk("busy_at_done", bus.busy, 0);
        chk("neg", bus.neg, exp_neg);
        chk("digits", digs(), shown(exp_bcd));
        prev_neg = exp_neg;
        prev_dig = shown(exp_bcd);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{12'h000, 1'b0, 16'h0000};
        vecs[1] = '{12'h7FF, 1'b0, 16'h2047};
        vecs[2] = '{12'h800, 1'b1, 16'h2048};
        vecs[3] = '{12'hFFF, 1'b1, 16'h0001};
        vecs[4] = '{12'h07B, 1'b0, 16'h0123};
        vecs[5] = '{12'h1F4, 1'b0, 16'h0500};
        vecs[6] = '{12'h3E7, 1'b0, 16'h0999};
        vecs[7] = '{12'hC18, 1'b1, 16'h1000};
        vecs[8] = '{12'h00A, 1'b0, 16'h0010};
        bus.start = 1'b0;
        bus.value = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out", {bus.neg, digs()}, 17'h0);
        @(negedge clk);
        rst = 1'b0;
        // Back-to-back: each start lands in the previous done cycle.
        for (int i = 0; i < 9; i++)
            run_conv(vecs[i].value, vecs[i].neg, vecs[i].bcd, 0, 12'h0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        // Second start at edge 5 is ignored; no extra done afterwards.
        run_conv(12'h07B, 1'b0, 16'h0123, 5, 12'h123);
        begin
            int extra = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.done || bus.busy) extra++;
            end
            chk("no_extra_done", extra, 0);
        end
        // Reset mid-conversion aborts asynchronously.
        bus.start = 1'b1;
        bus.value = 12'h1F4;
        repeat (6) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("busy_before_rst", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_out", {bus.neg, digs()}, 17'h0);
        @(negedge clk);
        rst = 1'b0;
        prev_neg = 1'b0;
        prev_dig = 16'h0000;
        chk("no_done_after_abort", bus.done, 0);
        run_conv(12'h1F4, 1'b0, 16'h0500, 0, 12'h0);
        @(negedge clk);
        chk("final_done_fall", bus.done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
